// File: rtl/menu_table_ctrl.sv
// ============================================================================
//  menu_table_ctrl : game-menu name table RAM, clear sweep and launch FSM
//  Revision 1.0    : initial release
// ============================================================================
`default_nettype none

module menu_table_ctrl #(
  parameter int         ROWS      = 8,
  parameter int         COLS      = 16,
  parameter logic [7:0] FILL_CHAR = 8'h20,
  localparam int        RW        = $clog2(ROWS),
  localparam int        CW        = $clog2(COLS)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [RW-1:0] wr_row,
  input  logic [CW-1:0] wr_col,
  input  logic [7:0]    wr_ch,
  input  logic          clr,
  output logic          busy,
  input  logic          rd_en,
  input  logic [RW-1:0] rd_row,
  input  logic [CW-1:0] rd_col,
  output logic [7:0]    rd_ch,
  output logic          rd_valid,
  input  logic [RW:0]   num_games,
  input  logic          btn_next,
  input  logic          btn_select,
  output logic [RW-1:0] sel,
  output logic          launch_valid,
  output logic [RW:0]   launch_index,
  input  logic          launch_ack
);

  localparam int AW    = RW + CW;
  localparam int DEPTH = ROWS * COLS;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_CLEAR  = 1'b1;
  localparam logic [0:0] ST_BROWSE = 1'b0;
  localparam logic [0:0] ST_LAUNCH = 1'b1;

  logic [7:0]    mem [DEPTH];

  logic [0:0]    clr_state_q, clr_state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic [7:0]    rd_ch_q, rd_ch_d;
  logic          rd_valid_q, rd_valid_d;
  logic [0:0]    sel_state_q, sel_state_d;
  logic [RW-1:0] sel_q, sel_d;
  logic [RW:0]   launch_index_q, launch_index_d;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;
  logic [RW:0]   ng_eff;
  logic [RW:0]   sel_inc;

  assign busy         = (clr_state_q == ST_CLEAR);
  assign wr_ready     = (clr_state_q == ST_IDLE) && !rd_en;
  assign rd_ch        = rd_ch_q;
  assign rd_valid     = rd_valid_q;
  assign sel          = sel_q;
  assign launch_valid = (sel_state_q == ST_LAUNCH);
  assign launch_index = launch_index_q;

  // Clear sweep: a clr pulse restarts at 0 without writing; rd_en stalls it
  always_comb begin
    clr_state_d = clr_state_q;
    clr_addr_d  = clr_addr_q;
    if (clr) begin
      clr_state_d = ST_CLEAR;
      clr_addr_d  = '0;
    end else if (clr_state_q == ST_CLEAR && !rd_en) begin
      clr_addr_d = clr_addr_q + 1'b1;
      if (clr_addr_q == AW'(DEPTH - 1)) begin
        clr_state_d = ST_IDLE;
      end
    end
  end

  // Single RAM port: video read, else sweep write, else CPU write
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clr_addr_q;
    mem_wdata = FILL_CHAR;
    if (!rd_en && resetn) begin
      if (clr_state_q == ST_CLEAR && !clr) begin
        mem_we = 1'b1;
      end else if (wr_valid && wr_ready) begin
        mem_we    = 1'b1;
        mem_waddr = {wr_row, wr_col};
        mem_wdata = wr_ch;
      end
    end
  end

  always_comb begin
    rd_ch_d    = rd_en ? mem[{rd_row, rd_col}] : rd_ch_q;
    rd_valid_d = rd_en;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    ng_eff         = (num_games > (RW+1)'(ROWS)) ? (RW+1)'(ROWS) : num_games;
    sel_inc        = {1'b0, sel_q} + (RW+1)'(1);
    sel_state_d    = sel_state_q;
    sel_d          = sel_q;
    launch_index_d = launch_index_q;
    if (sel_state_q == ST_BROWSE) begin
      if (btn_select && ng_eff != '0) begin
        launch_index_d = sel_inc;
        sel_state_d    = ST_LAUNCH;
      end else if (btn_next) begin
        sel_d = (sel_inc >= ng_eff) ? '0 : sel_inc[RW-1:0];
      end
    end else if (launch_ack) begin
      sel_state_d = ST_BROWSE;
    end
    // A shrunken game list pulls the highlight back to the first entry
    if ({1'b0, sel_q} >= ng_eff) begin
      sel_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clr_state_q    <= ST_CLEAR;
      clr_addr_q     <= '0;
      rd_ch_q        <= '0;
      rd_valid_q     <= 1'b0;
      sel_state_q    <= ST_BROWSE;
      sel_q          <= '0;
      launch_index_q <= '0;
    end else begin
      clr_state_q    <= clr_state_d;
      clr_addr_q     <= clr_addr_d;
      rd_ch_q        <= rd_ch_d;
      rd_valid_q     <= rd_valid_d;
      sel_state_q    <= sel_state_d;
      sel_q          <= sel_d;
      launch_index_q <= launch_index_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_menu_table_ctrl.sv
// ============================================================================
//  tb_menu_table_ctrl : directed self-checking bench with read scoreboard
//  Revision 1.0       : initial release
// ============================================================================
`default_nettype none

module tb_menu_table_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_row;
  logic [3:0] wr_col;
  logic [7:0] wr_ch;
  logic       clr;
  logic       busy;
  logic       rd_en;
  logic [2:0] rd_row;
  logic [3:0] rd_col;
  logic [7:0] rd_ch;
  logic       rd_valid;
  logic [3:0] num_games;
  logic       btn_next;
  logic       btn_select;
  logic [2:0] sel;
  logic       launch_valid;
  logic [3:0] launch_index;
  logic       launch_ack;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] model [128];
  logic [7:0] exp_q [$];
  int         n;

  menu_table_ctrl #(.ROWS(8), .COLS(16), .FILL_CHAR(8'h20)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_row       (wr_row),
    .wr_col       (wr_col),
    .wr_ch        (wr_ch),
    .clr          (clr),
    .busy         (busy),
    .rd_en        (rd_en),
    .rd_row       (rd_row),
    .rd_col       (rd_col),
    .rd_ch        (rd_ch),
    .rd_valid     (rd_valid),
    .num_games    (num_games),
    .btn_next     (btn_next),
    .btn_select   (btn_select),
    .sel          (sel),
    .launch_valid (launch_valid),
    .launch_index (launch_index),
    .launch_ack   (launch_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: record reads/writes the DUT will see, then score the result
  task automatic tick();
    logic rd_prev;
    #1;
    rd_prev = rd_en;
    if (rd_en) exp_q.push_back(model[{rd_row, rd_col}]);
    if (wr_valid && wr_ready) model[{wr_row, wr_col}] = wr_ch;
    @(posedge clk);
    #1;
    chk("rd_valid", {31'd0, rd_valid}, {31'd0, rd_prev});
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL sb_underflow observed=rd_valid expected=no_read");
      end else begin
        chk("rd_ch", {24'd0, rd_ch}, {24'd0, exp_q.pop_front()});
      end
    end
  endtask

  task automatic run_busy(output int cnt);
    cnt = 0;
    while (busy && cnt < 2000) begin
      tick();
      cnt++;
    end
  endtask

  task automatic press_next(input int times);
    for (int i = 0; i < times; i++) begin
      btn_next = 1'b1;
      tick();
      btn_next = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_sel"}, {29'd0, sel}, 32'd0);
    chk({tag, "_lvalid"}, {31'd0, launch_valid}, 32'd0);
    chk({tag, "_lindex"}, {28'd0, launch_index}, 32'd0);
    chk({tag, "_rd_ch"}, {24'd0, rd_ch}, 32'd0);
    chk({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
  endtask

  initial begin
    resetn = 1'b0; wr_valid = 1'b0; wr_row = '0; wr_col = '0; wr_ch = '0;
    clr = 1'b0; rd_en = 1'b0; rd_row = '0; rd_col = '0; num_games = '0;
    btn_next = 1'b0; btn_select = 1'b0; launch_ack = 1'b0;
    for (int i = 0; i < 128; i++) model[i] = 8'hxx;

    // Reset, then a full power-up sweep
    tick(); tick();
    check_reset_outputs("rst");
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    resetn = 1'b1;
    run_busy(n);
    chk("sweep_len", n, 128);
    for (int i = 0; i < 128; i++) model[i] = 8'h20;

    rd_en = 1'b1; rd_row = 3'd0; rd_col = 4'd0;
    tick();
    rd_row = 3'd7; rd_col = 4'd15;
    tick();
    rd_en = 1'b0;
    tick();
    chk("rd_hold", {24'd0, rd_ch}, 32'h20);

    // CPU write blocked by video reads
    wr_valid = 1'b1; wr_row = 3'd2; wr_col = 4'd5; wr_ch = 8'h41;
    rd_en = 1'b1; rd_row = 3'd0; rd_col = 4'd1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wr_blocked", {31'd0, wr_ready}, 32'd0);
      tick();
    end
    rd_en = 1'b0;
    #1;
    chk("wr_ready", {31'd0, wr_ready}, 32'd1);
    tick();
    wr_valid = 1'b0;
    rd_en = 1'b1; rd_row = 3'd2; rd_col = 4'd5;
    tick();
    rd_en = 1'b0;
    tick();

    // Selection wrap and ignored select with an empty list
    num_games = 4'd3;
    btn_next = 1'b1; tick(); btn_next = 1'b0; chk("sel_a", {29'd0, sel}, 32'd1);
    btn_next = 1'b1; tick(); btn_next = 1'b0; chk("sel_b", {29'd0, sel}, 32'd2);
    btn_next = 1'b1; tick(); btn_next = 1'b0; chk("sel_c", {29'd0, sel}, 32'd0);
    btn_next = 1'b1; tick(); btn_next = 1'b0; chk("sel_d", {29'd0, sel}, 32'd1);
    num_games = 4'd0;
    tick();
    chk("sel_empty", {29'd0, sel}, 32'd0);
    btn_select = 1'b1; tick(); btn_select = 1'b0;
    chk("lvalid_empty", {31'd0, launch_valid}, 32'd0);

    // Simultaneous next/select, LAUNCH ignores buttons, ack returns
    num_games = 4'd3;
    press_next(2);
    chk("sel_two", {29'd0, sel}, 32'd2);
    btn_next = 1'b1; btn_select = 1'b1;
    tick();
    btn_next = 1'b0; btn_select = 1'b0;
    chk("launch_valid", {31'd0, launch_valid}, 32'd1);
    chk("launch_index", {28'd0, launch_index}, 32'd3);
    chk("sel_launch", {29'd0, sel}, 32'd2);
    press_next(1);
    chk("sel_frozen", {29'd0, sel}, 32'd2);
    chk("launch_held", {28'd0, launch_index}, 32'd3);
    launch_ack = 1'b1; tick(); launch_ack = 1'b0;
    chk("launch_acked", {31'd0, launch_valid}, 32'd0);

    // Restarted sweep, then a sweep stretched by alternating reads
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 39; i++) tick();
    clr = 1'b1; tick(); clr = 1'b0;
    run_busy(n);
    chk("restart_len", n, 128);
    for (int i = 0; i < 128; i++) model[i] = 8'h20;
    clr = 1'b1; tick(); clr = 1'b0;
    n = 0;
    rd_row = 3'd0; rd_col = 4'd0;
    while (busy && n < 2000) begin
      rd_en = (n % 2 == 0);
      tick();
      n++;
    end
    rd_en = 1'b0;
    chk("stall_len", n, 256);
    tick();

    // num_games above ROWS behaves as ROWS
    num_games = 4'd15;
    press_next(5);
    chk("sel_clamp7", {29'd0, sel}, 32'd7);
    press_next(1);
    chk("sel_clamp_wrap", {29'd0, sel}, 32'd0);

    // Reset during a sweep and a pending launch
    num_games = 4'd3;
    clr = 1'b1; tick(); clr = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    btn_select = 1'b1; tick(); btn_select = 1'b0;
    chk("launch_pre_rst", {31'd0, launch_valid}, 32'd1);
    chk("lindex_pre_rst", {28'd0, launch_index}, 32'd1);
    resetn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick();
    resetn = 1'b1;
    run_busy(n);
    chk("rst_sweep_len", n, 128);

    num_games = 4'd8;
    press_next(5);
    chk("sel_five", {29'd0, sel}, 32'd5);
    num_games = 4'd4;
    tick();
    chk("sel_shrink", {29'd0, sel}, 32'd0);

    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
